// File: rtl/seq_compare_unit.sv
// seq_compare_unit: multi-cycle SLT/SLTU/MIN/MINU/MAX/MAXU/EQ/NE. Compares CHUNK bits per clock, most significant slice first.
// Latency: NSLICE edges from the accepting edge to rsp_valid_o. With SEQ_CMP_EARLY_TERM_EN: 1 + equal leading slices, which is data dependent.
// Backpressure: the result is held in DONE until rsp_ready_i. req_ready_o is high only in IDLE, so the completion cycle never accepts a new request.
module seq_compare_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rd_o
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             lt_q;
    logic             gt_q;
    logic [IDXW-1:0]  idx_q;

    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic             signed_op;
    logic             slice_lt;
    logic             slice_gt;
    logic             lt_fin;
    logic             gt_fin;
    logic             eq_fin;
    logic             cmp_last;
    logic             accept;
    logic [WIDTH-1:0] result;

    assign accept      = (state_q == ST_IDLE) && req_valid_i;
    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_DONE);

    // SLT, MIN and MAX are the signed ops. They are the even opcodes except EQ.
    assign signed_op = !op_q[0] && (op_q != 3'b110);

    // Select the current slice. For signed ops, flip the sign bit of the top slice so that an unsigned compare orders two's complement values.
    always_comb begin
        a_shift = a_q >> (int'(idx_q) * CHUNK);
        b_shift = b_q >> (int'(idx_q) * CHUNK);
        a_sl    = a_shift[CHUNK-1:0];
        b_sl    = b_shift[CHUNK-1:0];
        if (signed_op && (idx_q == IDX_TOP)) begin
            a_sl[CHUNK-1] = ~a_sl[CHUNK-1];
            b_sl[CHUNK-1] = ~b_sl[CHUNK-1];
        end
    end

    assign slice_lt = (a_sl < b_sl);
    assign slice_gt = (a_sl > b_sl);

    // Only the first differing slice decides. Once lt or gt is set, it sticks.
    assign lt_fin = lt_q || (!lt_q && !gt_q && slice_lt);
    assign gt_fin = gt_q || (!lt_q && !gt_q && slice_gt);
    assign eq_fin = !lt_fin && !gt_fin;

`ifdef SEQ_CMP_EARLY_TERM_EN
    // Early exit as soon as a slice differs. The timing leaks operand data.
    assign cmp_last = (idx_q == '0) || (!lt_q && !gt_q && (slice_lt || slice_gt));
`else
    // Always walk every slice, so latency never depends on the data.
    assign cmp_last = (idx_q == '0);
`endif

    // Result mux, evaluated on the final compare cycle. Equal operands select A for MIN/MAX.
    always_comb begin
        result = '0;
        case (op_q)
            3'b000, 3'b001: result = WIDTH'(lt_fin);
            3'b010, 3'b011: result = gt_fin ? b_q : a_q;
            3'b100, 3'b101: result = lt_fin ? b_q : a_q;
            3'b110:         result = WIDTH'(eq_fin);
            default:        result = WIDTH'(!eq_fin);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> BUSY on accept, BUSY -> DONE on the last slice, DONE -> IDLE on the consumer handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (cmp_last) state_d = ST_DONE;
            ST_DONE: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, accumulate the ordering per slice, and register the result on the last slice.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
            idx_q <= IDX_TOP;
            rd_o  <= '0;
        end else if (accept) begin
            a_q   <= rs1_i;
            b_q   <= rs2_i;
            op_q  <= op_i;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
            idx_q <= IDX_TOP;
        end else if (state_q == ST_BUSY) begin
            lt_q <= lt_fin;
            gt_q <= gt_fin;
            if (cmp_last) begin
                rd_o <= result;
            end else begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

endmodule
